// File: rtl/delay_timer.sv
// delay_timer: programmable delay timer with start/abort control, one-shot or
// periodic mode and optional retrigger. Expiry occurs every max+1 cycles of RUN.
// Latency: start sampled at edge E0 -> tick high in the cycle after edge E(max+1).
// Ports:
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-low reset
//   i_start      latch i_max/i_periodic and begin timing
//   i_abort      cancel any activity, return to IDLE, clear done (highest priority)
//   i_max        delay in cycles minus one
//   i_periodic   0 = one-shot, 1 = auto-reload on every expiry
//   o_busy       high while in RUN
//   o_tick       one-cycle pulse on every expiry
//   o_done       sticky expiry flag, cleared by an accepted start or abort
//   o_remaining  max_q - cnt while in RUN, 0 otherwise
// All outputs are registered; each is updated together with the state it reflects.
module delay_timer #(
  parameter int COUNTER_WIDTH = 10,
  parameter bit RETRIGGER     = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [COUNTER_WIDTH-1:0] i_max,
  input  logic                     i_periodic,
  output logic                     o_busy,
  output logic                     o_tick,
  output logic                     o_done,
  output logic [COUNTER_WIDTH-1:0] o_remaining
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10,
    S_ILL  = 2'b11
  } state_t;

  state_t                   r_state;
  logic [COUNTER_WIDTH-1:0] r_cnt;
  logic [COUNTER_WIDTH-1:0] r_max_q;
  logic                     r_per_q;

  // Compare happens before the increment, so the counter never wraps even
  // when max_q is all ones.
  logic w_expire;
  assign w_expire = (r_cnt == r_max_q);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_max_q     <= '0;
      r_per_q     <= 1'b0;
      o_busy      <= 1'b0;
      o_tick      <= 1'b0;
      o_done      <= 1'b0;
      o_remaining <= '0;
    end else begin
      o_tick <= 1'b0;
      if (i_abort) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        o_busy      <= 1'b0;
        o_done      <= 1'b0;
        o_remaining <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (i_start) begin
              r_state     <= S_RUN;
              r_max_q     <= i_max;
              r_per_q     <= i_periodic;
              r_cnt       <= '0;
              o_busy      <= 1'b1;
              o_done      <= 1'b0;
              o_remaining <= i_max;
            end
          end
          S_RUN: begin
            if (i_start && RETRIGGER) begin
              // Reload takes precedence over a coincident expiry; done is kept.
              r_max_q     <= i_max;
              r_per_q     <= i_periodic;
              r_cnt       <= '0;
              o_remaining <= i_max;
            end else if (w_expire) begin
              o_tick <= 1'b1;
              o_done <= 1'b1;
              r_cnt  <= '0;
              if (r_per_q) begin
                o_remaining <= r_max_q;
              end else begin
                r_state     <= S_DONE;
                o_busy      <= 1'b0;
                o_remaining <= '0;
              end
            end else begin
              r_cnt       <= r_cnt + COUNTER_WIDTH'(1);
              // Reflects the incremented count; cnt < max_q here so no underflow.
              o_remaining <= r_max_q - r_cnt - COUNTER_WIDTH'(1);
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_remaining <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delay_timer.sv
module tb_delay_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       periodic;
  logic [9:0] mx;

  logic       b0, t0, d0;
  logic [9:0] r0;
  logic       b1, t1, d1;
  logic [9:0] r1;
  logic       b2, t2, d2;
  logic [3:0] r2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // inst0: W=10 no retrigger, inst1: W=10 retrigger, inst2: W=4 no retrigger
  delay_timer #(.COUNTER_WIDTH(10), .RETRIGGER(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_max(mx),
    .i_periodic(periodic), .o_busy(b0), .o_tick(t0), .o_done(d0), .o_remaining(r0));
  delay_timer #(.COUNTER_WIDTH(10), .RETRIGGER(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_max(mx),
    .i_periodic(periodic), .o_busy(b1), .o_tick(t1), .o_done(d1), .o_remaining(r1));
  delay_timer #(.COUNTER_WIDTH(4), .RETRIGGER(1'b0)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_max(mx[3:0]),
    .i_periodic(periodic), .o_busy(b2), .o_tick(t2), .o_done(d2), .o_remaining(r2));

  // Reference model: a countdown of cycles left until the next expiry.
  bit m_run[3];
  bit m_tick[3];
  bit m_done[3];
  bit m_per[3];
  int m_left[3];
  int m_period[3];

  function automatic int inst_max(int i);
    return (i == 2) ? int'(mx[3:0]) : int'(mx);
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_run[i]    <= 1'b0;
        m_tick[i]   <= 1'b0;
        m_done[i]   <= 1'b0;
        m_per[i]    <= 1'b0;
        m_left[i]   <= 0;
        m_period[i] <= 0;
      end else begin
        m_tick[i] <= 1'b0;
        if (abort) begin
          m_run[i]  <= 1'b0;
          m_done[i] <= 1'b0;
          m_left[i] <= 0;
        end else if (start && (!m_run[i] || i == 1)) begin
          m_run[i]    <= 1'b1;
          m_left[i]   <= inst_max(i);
          m_period[i] <= inst_max(i);
          m_per[i]    <= periodic;
          if (!m_run[i]) m_done[i] <= 1'b0;
        end else if (m_run[i]) begin
          if (m_left[i] == 0) begin
            m_tick[i] <= 1'b1;
            m_done[i] <= 1'b1;
            if (m_per[i]) m_left[i] <= m_period[i];
            else          m_run[i]  <= 1'b0;
          end else begin
            m_left[i] <= m_left[i] - 1;
          end
        end
      end
    end
  end

  function automatic logic [12:0] exp_vec(int i);
    return {m_run[i], m_tick[i], m_done[i], m_run[i] ? 10'(m_left[i]) : 10'd0};
  endfunction

  function automatic logic [12:0] act_vec(int i);
    case (i)
      0:       return {b0, t0, d0, r0};
      1:       return {b1, t1, d1, r1};
      default: return {b2, t2, d2, 6'd0, r2};
    endcase
  endfunction

  task automatic step_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_abort();
    start = 1'b0;
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; periodic = 1'b0; mx = '0;
    repeat (3) step_clk();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_vec(i) !== 13'd0) begin
        errors++;
        $display("FAIL reset inst%0d got=%h want=%h", i, act_vec(i), 13'd0);
      end
    end
    rst = 1'b1;
    step_clk();
  endtask

  task automatic test_oneshot();
    int first = -1;
    int nt = 0;
    idle_abort();
    mx = 10'd4; periodic = 1'b0; start = 1'b1;
    step_clk();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step_clk();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL oneshot inst%0d E%0d got=%h want=%h", i, k, act_vec(i), exp_vec(i));
        end
      end
      if (t0) begin nt++; if (first < 0) first = k; end
    end
    checks++;
    if (first != 5 || nt != 1) begin
      errors++;
      $display("FAIL oneshot_tick first=%0d count=%0d want first=5 count=1", first, nt);
    end
    checks++;
    if ({b0, d0} !== 2'b01) begin
      errors++;
      $display("FAIL oneshot_final busy,done=%b want 01", {b0, d0});
    end
  endtask

  task automatic test_periodic();
    int first = -1;
    int nt = 0;
    idle_abort();
    mx = 10'd2; periodic = 1'b1; start = 1'b1;
    step_clk();
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) step_clk();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL periodic inst%0d E%0d got=%h want=%h", i, k, act_vec(i), exp_vec(i));
        end
      end
      if (t0) begin nt++; if (first < 0) first = k; end
    end
    checks++;
    if (first != 3 || nt != 3 || b0 !== 1'b1 || d0 !== 1'b1) begin
      errors++;
      $display("FAIL periodic_ticks first=%0d count=%0d busy=%b done=%b want 3 3 1 1",
               first, nt, b0, d0);
    end
  endtask

  task automatic test_boundary();
    int f0;
    int f2;
    idle_abort();
    mx = 10'd0; periodic = 1'b0; start = 1'b1;
    step_clk();
    start = 1'b0;
    f0 = -1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step_clk();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL max0 inst%0d E%0d got=%h want=%h", i, k, act_vec(i), exp_vec(i));
        end
      end
      if (t0 && f0 < 0) f0 = k;
    end
    checks++;
    if (f0 != 1) begin
      errors++;
      $display("FAIL max0_tick got=E%0d want=E1", f0);
    end
    // All-ones: inst2 sees 15 (16 cycles), inst0/1 see 1023 (1024 cycles).
    idle_abort();
    mx = 10'h3FF; start = 1'b1;
    step_clk();
    start = 1'b0;
    f0 = -1; f2 = -1;
    for (int k = 0; k < 1030; k++) begin
      if (k > 0) step_clk();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL maxall inst%0d E%0d got=%h want=%h", i, k, act_vec(i), exp_vec(i));
        end
      end
      if (t0 && f0 < 0) f0 = k;
      if (t2 && f2 < 0) f2 = k;
    end
    checks++;
    if (f2 != 16 || f0 != 1024) begin
      errors++;
      $display("FAIL maxall_tick got W4=E%0d W10=E%0d want E16 E1024", f2, f0);
    end
  endtask

  task automatic test_abort();
    idle_abort();
    mx = 10'd3; periodic = 1'b0; start = 1'b1;
    step_clk();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      abort = (k == 4);
      step_clk();
      abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL abort inst%0d E%0d got=%h want=%h", i, k, act_vec(i), exp_vec(i));
        end
      end
      if (k == 4) begin
        checks++;
        if ({b0, t0, d0} !== 3'b000) begin
          errors++;
          $display("FAIL abort_expiry busy,tick,done=%b want 000", {b0, t0, d0});
        end
      end
    end
    mx = 10'd2; start = 1'b1; abort = 1'b1;
    step_clk();
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({b1, t1, d1, r1} !== 13'd0) begin
      errors++;
      $display("FAIL abort_start got=%h want=%h", {b1, t1, d1, r1}, 13'd0);
    end
    for (int k = 0; k < 4; k++) begin
      step_clk();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL abort_start_idle inst%0d got=%h want=%h", i, act_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_retrigger();
    int f0 = -1;
    int f1 = -1;
    idle_abort();
    mx = 10'd5; periodic = 1'b0; start = 1'b1;
    step_clk();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      start = (k == 3);
      step_clk();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL retrig inst%0d E%0d got=%h want=%h", i, k, act_vec(i), exp_vec(i));
        end
      end
      if (t0 && f0 < 0) f0 = k;
      if (t1 && f1 < 0) f1 = k;
    end
    checks++;
    if (f0 != 6 || f1 != 9) begin
      errors++;
      $display("FAIL retrig_tick got R0=E%0d R1=E%0d want E6 E9", f0, f1);
    end
  endtask

  task automatic test_async_reset();
    int f0 = -1;
    idle_abort();
    mx = 10'd5; periodic = 1'b0; start = 1'b1;
    step_clk();
    start = 1'b0;
    repeat (3) step_clk();
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_vec(i) !== 13'd0 || exp_vec(i) !== 13'd0) begin
        errors++;
        $display("FAIL async_reset inst%0d got=%h want=%h", i, act_vec(i), 13'd0);
      end
    end
    #1 rst = 1'b1;
    @(negedge clk);
    mx = 10'd1; start = 1'b1;
    step_clk();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step_clk();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL post_reset inst%0d E%0d got=%h want=%h", i, k, act_vec(i), exp_vec(i));
        end
      end
      if (t0 && f0 < 0) f0 = k;
    end
    checks++;
    if (f0 != 2) begin
      errors++;
      $display("FAIL post_reset_tick got=E%0d want=E2", f0);
    end
  endtask

  task automatic test_random();
    idle_abort();
    for (int k = 0; k < 600; k++) begin
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 29) == 0);
      periodic = 1'($urandom_range(0, 1));
      mx       = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 40))
                                              : 10'($urandom_range(0, 6));
      step_clk();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d got=%h want=%h", i, k, act_vec(i), exp_vec(i));
        end
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_boundary();
    test_abort();
    test_retrigger();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
